// File: rtl/reg_fifo_nd.sv
// Register FIFO of DEPTH entries with valid/ready on both sides, fill level,
// almost-full/empty flags and a synchronous flush. Both handshake outputs are decoded from registered state.
module reg_fifo_nd #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic                         FLUSH_I,
  input  logic                         S_WVALID,
  output logic                         S_WREADY,
  input  logic [WIDTH-1:0]             S_WDATA,
  output logic                         M_WVALID,
  input  logic                         M_WREADY,
  output logic [WIDTH-1:0]             M_WDATA,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                         ALMOST_FULL,
  output logic                         ALMOST_EMPTY
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_LAST  = LW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_AEMPT = LW'(AEMPTY_TH);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wr;
  logic rd;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign S_WREADY     = (state_q != ST_FULL);
  assign M_WVALID     = (state_q != ST_EMPTY);
  assign M_WDATA      = mem_q[rp_q];
  assign LEVEL        = level_q;
  assign ALMOST_FULL  = (level_q >= LVL_AFULL);
  assign ALMOST_EMPTY = (level_q <= LVL_AEMPT);

  assign wr = S_WVALID & S_WREADY;
  assign rd = M_WVALID & M_WREADY;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this logic free of latches.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    state_d = state_q;
    mem_d   = mem_q;

    if (FLUSH_I) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      state_d = ST_EMPTY;
    end else begin
      if (wr) begin
        mem_d[wp_q] = S_WDATA;
        wp_d        = ptr_inc(wp_q);
      end
      if (rd) begin
        rp_d = ptr_inc(rp_q);
      end

      unique case ({wr, rd})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase

      case (state_q)
        ST_EMPTY: if (wr) state_d = ST_PART;
        ST_PART: begin
          if (wr && !rd && level_q == LVL_LAST) state_d = ST_FULL;
          else if (rd && !wr && level_q == LVL_ONE) state_d = ST_EMPTY;
        end
        ST_FULL:  if (rd) state_d = ST_PART;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the storage array is reset as well, because the head word must
  // read as zero straight out of reset; flush deliberately leaves it alone.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_EMPTY;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_reg_fifo_nd.sv
// Bench for reg_fifo_nd: a DEPTH=4 and a DEPTH=3 instance share one stimulus stream;
// each has its own queue-based reference model and scoreboard.
module tb_reg_fifo_nd;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       s_wvalid;
  logic       m_wready;
  logic [7:0] s_wdata;
  logic       mon_en = 1'b0;

  logic       s_wready  [2];
  logic       m_wvalid  [2];
  logic [7:0] m_wdata   [2];
  logic       afull     [2];
  logic       aempty    [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D  = (g == 0) ? 4 : 3;
    localparam int AF = (g == 0) ? 3 : 2;
    localparam int AE = (g == 0) ? 1 : 0;

    logic [$clog2(D+1)-1:0] level;
    logic [7:0]             q [$];
    int                     sz;

    reg_fifo_nd #(.WIDTH(8), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_dut (
      .CLK_I        (clk),
      .RST_I        (rst),
      .FLUSH_I      (flush),
      .S_WVALID     (s_wvalid),
      .S_WREADY     (s_wready[g]),
      .S_WDATA      (s_wdata),
      .M_WVALID     (m_wvalid[g]),
      .M_WREADY     (m_wready),
      .M_WDATA      (m_wdata[g]),
      .LEVEL        (level),
      .ALMOST_FULL  (afull[g]),
      .ALMOST_EMPTY (aempty[g])
    );

    // Mid-cycle: compare DUT against the model, then advance the model by
    // what the coming edge will do to a FIFO of D entries.
    always @(negedge clk) begin
      if (mon_en) begin
        sz = q.size();
        check(g, "level",    32'(level),       32'(sz));
        check(g, "s_wready", 32'(s_wready[g]), 32'(sz < D));
        check(g, "m_wvalid", 32'(m_wvalid[g]), 32'(sz > 0));
        check(g, "afull",    32'(afull[g]),    32'(sz >= AF));
        check(g, "aempty",   32'(aempty[g]),   32'(sz <= AE));
        if (sz > 0) check(g, "m_wdata", 32'(m_wdata[g]), 32'(q[0]));

        if (rst || flush) begin
          q.delete();
        end else begin
          if (m_wready && sz > 0) void'(q.pop_front());
          if (s_wvalid && sz < D) q.push_back(s_wdata);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic r, input logic [7:0] d, input logic f);
    @(posedge clk);
    #1;
    s_wvalid = v;
    m_wready = r;
    s_wdata  = d;
    flush    = f;
  endtask

  initial begin
    int pv;
    int pr;

    rst      = 1'b1;
    flush    = 1'b0;
    s_wvalid = 1'b0;
    m_wready = 1'b0;
    s_wdata  = '0;

    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(0, "rst_wdata", 32'(m_wdata[0]), 32'h0);
    check(1, "rst_wdata", 32'(m_wdata[1]), 32'h0);

    // Fill to full, then hold a fifth word that must not be taken.
    drive(1, 0, 8'h11, 0);
    drive(1, 0, 8'h22, 0);
    drive(1, 0, 8'h33, 0);
    drive(1, 0, 8'h44, 0);
    drive(1, 0, 8'h55, 0);
    drive(1, 0, 8'h55, 0);

    // Read from full: first cycle read only, then read and write together.
    drive(1, 1, 8'h55, 0);
    drive(1, 1, 8'h55, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'h00, 0);

    // Streaming with incrementing data; the DEPTH=3 instance exercises wrap.
    for (int i = 0; i < 20; i++) drive(1, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h00, 0);

    // Flush with a concurrent write, then a fresh word must come out first.
    drive(1, 0, 8'hC1, 0);
    drive(1, 0, 8'hC2, 0);
    drive(1, 0, 8'hC3, 0);
    drive(1, 0, 8'h77, 1);
    drive(1, 0, 8'hA5, 0);
    drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h00, 0);

    // Random traffic with phase-varying bias, occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      pv = 20 + 25 * ((i / 1000) % 4);
      pr = 80 - 20 * ((i / 700) % 4);
      @(posedge clk);
      #1;
      rst      = ($urandom_range(0, 1999) == 0);
      flush    = ($urandom_range(0, 199) == 0);
      s_wvalid = ($urandom_range(0, 99) < pv);
      m_wready = ($urandom_range(0, 99) < pr);
      s_wdata  = 8'($urandom);
    end

    @(posedge clk);
    #1;
    rst      = 1'b0;
    flush    = 1'b0;
    s_wvalid = 1'b0;
    m_wready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
